// File: rtl/wave_generator.sv
// Sample-rate waveform engine: phase accumulator plus saw/square/triangle/parabolic-sine
// shaping, delivering one DAC command word per sample period with a one-cycle send strobe.
module wave_generator #(
    parameter int unsigned SAMPLE_INTERVAL = 2015,
    parameter logic [7:0]  DAC_CMD         = 8'b00110001
) (
    input  logic        clock_in,
    input  logic        rstn,
    input  logic [15:0] freq_in,
    input  logic        freq_valid,
    input  logic [1:0]  wave_sel,
    output logic [23:0] dac_data,
    output logic        send,
    output logic        busy,
    output logic        overrun
);

    localparam int TIMER_W = $clog2(SAMPLE_INTERVAL + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_INTERVAL);

    // state | meaning
    // IDLE  | waiting for the sample tick
    // SHAPE | direct waves computed, or sine multiplier loaded
    // MUL   | one shift-add step per cycle, 15 steps
    // FOLD  | product folded around mid-scale into the sine sample
    // OUT   | DAC word registered with send strobe
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHAPE,
        ST_MUL,
        ST_FOLD,
        ST_OUT
    } state_t;

    state_t              state_q,    state_d;
    logic [TIMER_W-1:0]  timer_q,    timer_d;
    logic [23:0]         phase_q,    phase_d;
    logic [15:0]         freq_reg_q, freq_reg_d;
    logic [15:0]         p_q,        p_d;
    logic [1:0]          wave_q,     wave_d;
    logic [29:0]         mcand_q,    mcand_d;
    logic [14:0]         mplier_q,   mplier_d;
    logic [29:0]         prod_q,     prod_d;
    logic [3:0]          cnt_q,      cnt_d;
    logic [15:0]         sample_q,   sample_d;
    logic [23:0]         dac_data_q, dac_data_d;
    logic                send_q,     send_d;
    logic                overrun_q,  overrun_d;

    logic                tick;
    logic [15:0]         tri_val;
    logic [15:0]         fold_m;

    assign tick    = (timer_q == TIMER_LAST);
    assign tri_val = {p_q[14:0], 1'b0};
    assign fold_m  = prod_q[28:13];

    always_comb begin
        state_d    = state_q;
        timer_d    = tick ? '0 : timer_q + TIMER_W'(1);
        phase_d    = phase_q;
        freq_reg_d = freq_valid ? freq_in : freq_reg_q;
        p_d        = p_q;
        wave_d     = wave_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        dac_data_d = dac_data_q;
        send_d     = 1'b0;
        overrun_d  = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    p_d     = phase_q[23:8];
                    wave_d  = wave_sel;
                    phase_d = phase_q + {8'b0, freq_reg_q};
                    state_d = ST_SHAPE;
                end
            end
            ST_SHAPE: begin
                state_d = ST_OUT;
                unique case (wave_q)
                    2'd0: sample_d = p_q;
                    2'd1: sample_d = {16{p_q[15]}};
                    2'd2: sample_d = p_q[15] ? ~tri_val : tri_val;
                    default: begin
                        mcand_d  = {15'b0, p_q[14:0]};
                        mplier_d = ~p_q[14:0];
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end
                endcase
            end
            ST_MUL: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = {mcand_q[28:0], 1'b0};
                mplier_d = {1'b0, mplier_q[14:1]};
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd14) begin
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                sample_d = p_q[15] ? (16'h8000 - fold_m) : (16'h8000 + fold_m);
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                dac_data_d = {DAC_CMD, sample_q};
                send_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A tick that finds the engine busy is dropped; the phase stays put.
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            phase_q    <= '0;
            freq_reg_q <= '0;
            p_q        <= '0;
            wave_q     <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            sample_q   <= '0;
            dac_data_q <= '0;
            send_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            phase_q    <= phase_d;
            freq_reg_q <= freq_reg_d;
            p_q        <= p_d;
            wave_q     <= wave_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            dac_data_q <= dac_data_d;
            send_q     <= send_d;
            overrun_q  <= overrun_d;
        end
    end

    assign dac_data = dac_data_q;
    assign send     = send_q;
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = overrun_q;

endmodule
